ioctl_rom_router: RTL and testbench
===================================

// Module: ioctl_rom_router
// PURPOSE
//  Parametrised successor to the inline ioctl handling in the emu top: accepts the hps_io 16-bit
//  ioctl download stream, splits each word into two byte writes, decodes the target ROM region
//  from a base-address table, applies ioctl_wait backpressure, and captures DIP bytes (index 254).
//  Sits between hps_io and the core's ROM/DIP inputs; the core consumes one byte write at a time.
// PARAMETERS
//  NUM_REGIONS  4          number of ROM regions (1..8)
//  REGION_BASE  {...}      packed NUM_REGIONS x ADDR_W ascending byte base addresses; region 0 base = 0
//  ADDR_W       27         ioctl_addr width
//  OUT_AW       20         rom_addr width (offset within region)
//  DIP_BYTES    8          DIP bytes captured (1..16)
//  ROM_INDEX    0          ioctl_index routed to ROM regions
//  DIP_INDEX    254        ioctl_index routed to DIP capture
// PORTS
//  clk_sys         in   1            system clock
//  reset_n         in   1            asynchronous, active-low reset
//  ioctl_download  in   1            download active
//  ioctl_index     in   8            download target index
//  ioctl_wr        in   1            word strobe (single cycle)
//  ioctl_addr      in   ADDR_W       byte address of dout[7:0]
//  ioctl_dout      in   16           data; [7:0]@addr, [15:8]@addr+1
//  ioctl_wait      out  1            backpressure to hps_io
//  rom_wr          out  1            byte write valid
//  rom_ready       in   1            sink accepts when rom_wr&&rom_ready
//  rom_region      out  $clog2(NUM_REGIONS) region select
//  rom_addr        out  OUT_AW       byte offset in region
//  rom_data        out  8            byte
//  dip             out  8*DIP_BYTES  captured DIP bytes, byte n at [8n+7:8n]
//  rom_done        out  1            one-cycle pulse when a ROM download ends
//  rom_checksum    out  16           additive checksum (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: ioctl_wait=0, rom_wr=0, rom_region/addr/data=0, dip=all 1s (8'hFF each), rom_done=0, rom_checksum=0, FSM IDLE.
//  - FSM IDLE -> LO on ioctl_wr && download && index==ROM_INDEX: latch addr/dout, raise ioctl_wait same edge.
//    LO: rom_wr=1 with dout[7:0] @addr; on accept -> HI. HI: dout[15:8] @addr+1; on accept -> IDLE, drop wait.
//  - Minimum 3 cycles/word with rom_ready=1; wait held high from cycle after wr until HI accepted.
//  - rom_wr/region/addr/data stable while rom_wr && !rom_ready.
//  - Region decode per byte: highest i with byte_addr >= REGION_BASE[i]; rom_addr = byte_addr - base (truncated to OUT_AW).
//    HI byte may fall in next region if addr+1 crosses a base; decoded independently.
//  - ioctl_wr while not IDLE: protocol violation, word ignored (hps_io honours wait).
//  - DIP: ioctl_wr && index==DIP_INDEX && addr < DIP_BYTES -> dip byte[addr] <= dout[7:0], no wait, no rom_wr; addr>=DIP_BYTES ignored.
//  - Other indices ignored entirely.
//  - rom_done: registered falling edge of (download && index==ROM_INDEX), emitted only once FSM IDLE (deferred if a word is in flight).
//  - Download deasserting mid-word: in-flight bytes still complete.
//  - Reset mid-word: FSM IDLE immediately, partial word lost, wait drops; dip returns to 8'hFF.
// CONFIGURATION
//  IOCTL_ROM_ROUTER_CHECKSUM_EN defined: rom_checksum = 16-bit wrapping sum of all accepted ROM bytes,
//   cleared on rising edge of ROM download, frozen after rom_done. Undefined: rom_checksum tied 16'h0000, no adder.
// STRUCTURE
//  - Package ioctl_rom_router_pkg: FSM state enum (IDLE/LO/HI), DEFAULT_DIP=8'hFF, default index constants.
//  - Sub-module ioctl_region_decode: combinational address->{region, offset} from REGION_BASE; instanced once, fed by byte address mux.
// TESTING
//  1. NUM_REGIONS=2, BASE={0,'h8000}; wr addr 'h0010 dout 'hBEEF, ready=1 -> bytes (r0,'h10,'hEF),(r0,'h11,'hBE); wait high 2 cycles.
//  2. wr addr 'h7FFF dout 'h1234 -> (r0,'h7FFF,'h34) then (r1,'h0000,'h12).
//  3. rom_ready low 5 cycles during LO -> rom_wr/addr/data held, wait held, no byte lost or duplicated.
//  4. index 254 addr 1 dout 'h00A5 -> dip[15:8]='hA5, others 'hFF, rom_wr never asserts; addr 9 with DIP_BYTES=8 -> no change.
//  5. download drops while in HI with ready low -> rom_done pulses exactly once, one cycle after HI accepted.
//  6. CHECKSUM_EN: bytes 'hFF,'h02 -> rom_checksum='h0101; reset_n low mid-word -> all outputs reset values asynchronously.

Source files
------------

// File: rtl/ioctl_rom_router_pkg.sv
// Shared types and constants for the ioctl ROM/DIP router.
package ioctl_rom_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_e;

  localparam logic [7:0] DEFAULT_DIP   = 8'hFF;
  localparam logic [7:0] ROM_INDEX_DEF = 8'd0;
  localparam logic [7:0] DIP_INDEX_DEF = 8'd254;

  // Select width that never collapses to zero for a single region.
  function automatic int unsigned region_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ioctl_region_decode.sv
// Maps a byte address to {region, offset} using an ascending base-address table.
module ioctl_region_decode
  import ioctl_rom_router_pkg::*;
#(
  parameter int unsigned                    NUM_REGIONS = 4,
  parameter int unsigned                    ADDR_W      = 27,
  parameter int unsigned                    OUT_AW      = 20,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE = '0
) (
  input  logic [ADDR_W-1:0]                       i_addr,
  output logic [region_w(NUM_REGIONS)-1:0]        o_region,
  output logic [OUT_AW-1:0]                       o_offset
);

  localparam int unsigned RW = region_w(NUM_REGIONS);

  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_diff;

  // Highest region whose base is at or below the address wins.
  always_comb begin
    w_base   = REGION_BASE[ADDR_W-1:0];
    o_region = '0;
    for (int i = 1; i < int'(NUM_REGIONS); i++) begin
      if (i_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        o_region = RW'(i);
        w_base   = REGION_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_diff   = i_addr - w_base;
  assign o_offset = OUT_AW'(w_diff);

endmodule

// File: rtl/ioctl_rom_router.sv
// Splits the hps_io 16-bit ioctl stream into region-decoded ROM byte writes and captures DIP bytes.
// Optional running byte checksum enabled by defining IOCTL_ROM_ROUTER_CHECKSUM_EN.
module ioctl_rom_router
  import ioctl_rom_router_pkg::*;
#(
  parameter int unsigned                    NUM_REGIONS = 4,
  parameter int unsigned                    ADDR_W      = 27,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE = {27'h0030000, 27'h0020000,
                                                           27'h0010000, 27'h0000000},
  parameter int unsigned                    OUT_AW      = 20,
  parameter int unsigned                    DIP_BYTES   = 8,
  parameter logic [7:0]                     ROM_INDEX   = ROM_INDEX_DEF,
  parameter logic [7:0]                     DIP_INDEX   = DIP_INDEX_DEF
) (
  input  logic                                clk_sys,
  input  logic                                reset_n,
  input  logic                                ioctl_download,
  input  logic [7:0]                          ioctl_index,
  input  logic                                ioctl_wr,
  input  logic [ADDR_W-1:0]                   ioctl_addr,
  input  logic [15:0]                         ioctl_dout,
  output logic                                ioctl_wait,
  output logic                                rom_wr,
  input  logic                                rom_ready,
  output logic [region_w(NUM_REGIONS)-1:0]    rom_region,
  output logic [OUT_AW-1:0]                   rom_addr,
  output logic [7:0]                          rom_data,
  output logic [8*DIP_BYTES-1:0]              dip,
  output logic                                rom_done,
  output logic [15:0]                         rom_checksum
);

  localparam int unsigned RW = region_w(NUM_REGIONS);

  state_e            r_state, w_state_nxt;
  logic              r_wait, w_wait_nxt;
  logic              r_wr, w_wr_nxt;
  logic [RW-1:0]     r_region, w_region_nxt;
  logic [OUT_AW-1:0] r_rom_addr, w_rom_addr_nxt;
  logic [7:0]        r_data, w_data_nxt;
  logic [ADDR_W-1:0] r_word_addr;
  logic [7:0]        r_hi_byte;
  logic [8*DIP_BYTES-1:0] r_dip;
  logic              r_rom_dl, r_done_pend, r_done;

  logic              w_rom_dl, w_fall, w_accept, w_rom_word, w_dip_wr;
  logic [ADDR_W-1:0] w_byte_addr;
  logic [RW-1:0]     w_dec_region;
  logic [OUT_AW-1:0] w_dec_offset;

  assign w_rom_dl   = ioctl_download && (ioctl_index == ROM_INDEX);
  assign w_fall     = r_rom_dl && !w_rom_dl;
  assign w_accept   = r_wr && rom_ready;
  assign w_rom_word = ioctl_wr && w_rom_dl;
  assign w_dip_wr   = ioctl_wr && (ioctl_index == DIP_INDEX) &&
                      (ioctl_addr < ADDR_W'(DIP_BYTES));

  // Low byte decodes the live address; high byte decodes the latched address + 1.
  assign w_byte_addr = (r_state == ST_IDLE) ? ioctl_addr : (r_word_addr + ADDR_W'(1));

  ioctl_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .OUT_AW      (OUT_AW),
    .REGION_BASE (REGION_BASE)
  ) u_decode (
    .i_addr   (w_byte_addr),
    .o_region (w_dec_region),
    .o_offset (w_dec_offset)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and next registered outputs; everything holds unless a transition fires.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_nxt     = r_wait;
    w_wr_nxt       = r_wr;
    w_region_nxt   = r_region;
    w_rom_addr_nxt = r_rom_addr;
    w_data_nxt     = r_data;
    case (r_state)
      ST_IDLE: begin
        if (w_rom_word) begin
          w_state_nxt    = ST_LO;
          w_wait_nxt     = 1'b1;
          w_wr_nxt       = 1'b1;
          w_region_nxt   = w_dec_region;
          w_rom_addr_nxt = w_dec_offset;
          w_data_nxt     = ioctl_dout[7:0];
        end
      end
      ST_LO: begin
        if (w_accept) begin
          w_state_nxt    = ST_HI;
          w_region_nxt   = w_dec_region;
          w_rom_addr_nxt = w_dec_offset;
          w_data_nxt     = r_hi_byte;
        end
      end
      ST_HI: begin
        if (w_accept) begin
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = 1'b0;
          w_wr_nxt    = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wait_nxt  = 1'b0;
        w_wr_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wait      <= 1'b0;
      r_wr        <= 1'b0;
      r_region    <= '0;
      r_rom_addr  <= '0;
      r_data      <= '0;
      r_word_addr <= '0;
      r_hi_byte   <= '0;
    end else begin
      r_wait     <= w_wait_nxt;
      r_wr       <= w_wr_nxt;
      r_region   <= w_region_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_data     <= w_data_nxt;
      if (r_state == ST_IDLE && w_rom_word) begin
        r_word_addr <= ioctl_addr;
        r_hi_byte   <= ioctl_dout[15:8];
      end
    end
  end

  // DIP capture is independent of the ROM word path and never stalls hps_io.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dip <= {DIP_BYTES{DEFAULT_DIP}};
    end else begin
      for (int i = 0; i < int'(DIP_BYTES); i++) begin
        if (w_dip_wr && (ioctl_addr == ADDR_W'(i))) r_dip[8*i +: 8] <= ioctl_dout[7:0];
      end
    end
  end

  // End-of-download pulse waits until the in-flight word has fully drained.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_dl    <= 1'b0;
      r_done_pend <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rom_dl    <= w_rom_dl;
      r_done      <= (r_done_pend || w_fall) && (r_state == ST_IDLE);
      r_done_pend <= (r_done_pend || w_fall) && (r_state != ST_IDLE);
    end
  end

`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
  logic        w_rise;
  logic [15:0] r_csum;

  assign w_rise = !r_rom_dl && w_rom_dl;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)      r_csum <= '0;
    else if (w_rise)   r_csum <= '0;
    else if (w_accept) r_csum <= r_csum + 16'(r_data);
  end

  assign rom_checksum = r_csum;
`else
  assign rom_checksum = 16'h0000;
`endif

  assign ioctl_wait = r_wait;
  assign rom_wr     = r_wr;
  assign rom_region = r_region;
  assign rom_addr   = r_rom_addr;
  assign rom_data   = r_data;
  assign dip        = r_dip;
  assign rom_done   = r_done;

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Directed bench for ioctl_rom_router with two regions (bases 0 and 'h8000).
module tb_ioctl_rom_router;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        rom_wr;
  logic        rom_ready;
  logic [0:0]  rom_region;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data;
  logic [63:0] dip;
  logic        rom_done;
  logic [15:0] rom_checksum;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_done   = 0;
  int done_base;

`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
  localparam logic [15:0] EXP_CSUM = 16'h0101;
`else
  localparam logic [15:0] EXP_CSUM = 16'h0000;
`endif

  ioctl_rom_router #(
    .NUM_REGIONS (2),
    .ADDR_W      (27),
    .REGION_BASE ({27'h0008000, 27'h0000000}),
    .OUT_AW      (20),
    .DIP_BYTES   (8),
    .ROM_INDEX   (8'd0),
    .DIP_INDEX   (8'd254)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rom_wr         (rom_wr),
    .rom_ready      (rom_ready),
    .rom_region     (rom_region),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .dip            (dip),
    .rom_done       (rom_done),
    .rom_checksum   (rom_checksum)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (rom_wr && rom_ready) n_acc++;
    if (rom_done) n_done++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_out(input string tag, input logic wr, input logic reg_sel,
                           input logic [19:0] addr, input logic [7:0] data, input logic wt);
    check({tag, " rom_wr"}, 64'(rom_wr), 64'(wr));
    check({tag, " wait"}, 64'(ioctl_wait), 64'(wt));
    if (wr) begin
      check({tag, " region"}, 64'(rom_region), 64'(reg_sel));
      check({tag, " addr"}, 64'(rom_addr), 64'(addr));
      check({tag, " data"}, 64'(rom_data), 64'(data));
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " wait"}, 64'(ioctl_wait), 64'h0);
    check({tag, " rom_wr"}, 64'(rom_wr), 64'h0);
    check({tag, " region"}, 64'(rom_region), 64'h0);
    check({tag, " addr"}, 64'(rom_addr), 64'h0);
    check({tag, " data"}, 64'(rom_data), 64'h0);
    check({tag, " dip"}, dip, 64'hFFFF_FFFF_FFFF_FFFF);
    check({tag, " done"}, 64'(rom_done), 64'h0);
    check({tag, " csum"}, 64'(rom_checksum), 64'h0);
  endtask

  task automatic wr_word(input logic [7:0] idx, input logic [26:0] addr, input logic [15:0] dout);
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = dout;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr    = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    rom_ready      = 1'b1;
    #12;
    check_reset("reset");
    reset_n = 1'b1;
    tick();

    // Plain word, both bytes in region 0.
    ioctl_download = 1'b1;
    wr_word(8'd0, 27'h10, 16'hBEEF);
    check_out("t1 lo", 1'b1, 1'b0, 20'h10, 8'hEF, 1'b1);
    tick();
    check_out("t1 hi", 1'b1, 1'b0, 20'h11, 8'hBE, 1'b1);
    tick();
    check_out("t1 idle", 1'b0, 1'b0, 20'h0, 8'h0, 1'b0);

    // High byte crosses into region 1.
    wr_word(8'd0, 27'h7FFF, 16'h1234);
    check_out("t2 lo", 1'b1, 1'b0, 20'h7FFF, 8'h34, 1'b1);
    tick();
    check_out("t2 hi", 1'b1, 1'b1, 20'h0000, 8'h12, 1'b1);
    tick();
    check_out("t2 idle", 1'b0, 1'b0, 20'h0, 8'h0, 1'b0);

    // Sink stall during the low byte.
    rom_ready = 1'b0;
    wr_word(8'd0, 27'h20, 16'h5A3C);
    check_out("t3 lo", 1'b1, 1'b0, 20'h20, 8'h3C, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("t3 hold", 1'b1, 1'b0, 20'h20, 8'h3C, 1'b1);
    end
    rom_ready = 1'b1;
    tick();
    check_out("t3 hi", 1'b1, 1'b0, 20'h21, 8'h5A, 1'b1);
    tick();
    check_out("t3 idle", 1'b0, 1'b0, 20'h0, 8'h0, 1'b0);
    check("t3 accepted", 64'(n_acc), 64'd6);

    // DIP capture; switching index away from ROM ends the ROM download.
    wr_word(8'd254, 27'h1, 16'h00A5);
    check("t4 dip a1", dip, 64'hFFFF_FFFF_FFFF_A5FF);
    check("t4 done idle", 64'(rom_done), 64'h1);
    check("t4 no rom_wr", 64'(rom_wr), 64'h0);
    check("t4 no wait", 64'(ioctl_wait), 64'h0);
    wr_word(8'd254, 27'h9, 16'h0011);
    check("t4 dip a9", dip, 64'hFFFF_FFFF_FFFF_A5FF);
    wr_word(8'd254, 27'h8, 16'h0022);
    check("t4 dip a8", dip, 64'hFFFF_FFFF_FFFF_A5FF);
    wr_word(8'd254, 27'h7, 16'h0033);
    check("t4 dip a7", dip, 64'h33FF_FFFF_FFFF_A5FF);
    wr_word(8'd5, 27'h30, 16'h1111);
    check("t4 other idx", 64'(rom_wr), 64'h0);
    tick();
    check("t4 accepted", 64'(n_acc), 64'd6);

    // Download drops while the high byte is stalled.
    rom_ready = 1'b0;
    wr_word(8'd0, 27'h40, 16'h7788);
    check_out("t5 lo", 1'b1, 1'b0, 20'h40, 8'h88, 1'b1);
    rom_ready = 1'b1;
    tick();
    check_out("t5 hi", 1'b1, 1'b0, 20'h41, 8'h77, 1'b1);
    rom_ready      = 1'b0;
    ioctl_download = 1'b0;
    done_base      = n_done;
    tick();
    check("t5 done early1", 64'(rom_done), 64'h0);
    check_out("t5 hi held", 1'b1, 1'b0, 20'h41, 8'h77, 1'b1);
    tick();
    check("t5 done early2", 64'(rom_done), 64'h0);
    rom_ready = 1'b1;
    tick();
    check_out("t5 idle", 1'b0, 1'b0, 20'h0, 8'h0, 1'b0);
    check("t5 done at accept", 64'(rom_done), 64'h0);
    tick();
    check("t5 done pulse", 64'(rom_done), 64'h1);
    tick();
    check("t5 done end", 64'(rom_done), 64'h0);
    check("t5 done count", 64'(n_done - done_base), 64'd1);

    // Checksum of a fresh download, then reset mid-word.
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick();
    wr_word(8'd0, 27'h0, 16'h02FF);
    tick();
    tick();
    check("t6 csum", 64'(rom_checksum), 64'(EXP_CSUM));
    rom_ready = 1'b0;
    wr_word(8'd0, 27'h8001, 16'h3344);
    check_out("t6 lo r1", 1'b1, 1'b1, 20'h1, 8'h44, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("t6 async rst");
    #3;
    reset_n = 1'b1;
    tick();
    check_out("t6 after rst", 1'b0, 1'b0, 20'h0, 8'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
